// File: rtl/ctrl_pkg.sv
// Shared constants and types for the ID-stage control unit.
// Imported by the decoder pipeline and the condition evaluator.
package ctrl_pkg;

    localparam logic [1:0] MODE_NORM = 2'b00;
    localparam logic [1:0] MODE_MEM  = 2'b01;
    localparam logic [1:0] MODE_BR   = 2'b10;
    localparam logic [1:0] MODE_RSV  = 2'b11;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0] cmd;
        logic       mem_read;
        logic       mem_write;
        logic       wb;
        logic       branch;
        logic       s;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_cond_eval.sv
// ARM condition-field evaluator against {N,Z,C,V}.
// Pure combinational; shared with the branch unit.
module ctrl_cond_eval
    import ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);

    logic n, z, c, v;

    assign {n, z, c, v} = nzcv_i;

    always_comb begin
        pass_o = 1'b0;
        unique case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = !z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = !c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = !n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = !v;
            COND_HI: pass_o = c && !z;
            COND_LS: pass_o = !c || z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = !z && (n == v);
            COND_LE: pass_o = z || (n != v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_unit_pipe.sv
// ID-stage control decode, load-use interlock and ID/EX register.
// Drives the IF/ID hold and a bubble-capable EX control bundle.
module ctrl_unit_pipe
    import ctrl_pkg::*;
#(
    parameter int CMD_W             = 4,
    parameter int RA_W              = 4,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [3:0]       opcode,
    input  logic             s_in,
    input  logic             imm_32_en,
    input  logic [3:0]       cond,
    input  logic [3:0]       status_nzcv,
    input  logic [RA_W-1:0]  src1,
    input  logic [RA_W-1:0]  src2,
    input  logic             two_src,
    input  logic [RA_W-1:0]  dst,
    input  logic             ext_stall,
    input  logic             branch_flush,
    output logic             ex_valid,
    output logic [CMD_W-1:0] ex_cmd,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_wb_en,
    output logic             ex_branch,
    output logic             ex_s,
    output logic [RA_W-1:0]  ex_dst,
    output logic             id_stall
);

    localparam logic [2:0] CNT_INIT =
        3'((LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0);

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            ex_valid_q, ex_valid_d;
    ctrl_t           ex_q, ex_d;
    logic [RA_W-1:0] ex_dst_q, ex_dst_d;

    ctrl_t dec;
    logic  cond_pass;
    logic  hazard;
    logic  stall_c;

    ctrl_cond_eval u_cond (
        .cond_i (cond),
        .nzcv_i (status_nzcv),
        .pass_o (cond_pass)
    );

    always_comb begin
        dec = CTRL_NOP;
        case (mode)
            MODE_MEM: begin
                dec.cmd = CMD_ADD;
                if (s_in) begin
                    dec.mem_read = 1'b1;
                    dec.wb       = 1'b1;
                end else begin
                    dec.mem_write = 1'b1;
                end
            end
            MODE_BR: dec.branch = 1'b1;
            MODE_NORM: begin
                case (opcode)
                    OP_MOV:  dec.cmd = CMD_MOV;
                    OP_MVN:  dec.cmd = CMD_MVN;
                    OP_ADD:  dec.cmd = CMD_ADD;
                    OP_ADC:  dec.cmd = CMD_ADC;
                    OP_SUB:  dec.cmd = CMD_SUB;
                    OP_SBC:  dec.cmd = CMD_SBC;
                    OP_AND:  dec.cmd = CMD_AND;
                    OP_ORR:  dec.cmd = CMD_ORR;
                    OP_EOR:  dec.cmd = CMD_EOR;
                    OP_CMP:  dec.cmd = CMD_SUB;
                    OP_TST:  dec.cmd = CMD_AND;
                    default: dec.cmd = CMD_NOP;
                endcase
                // compares only set flags; everything else listed writes back
                if (opcode == OP_CMP || opcode == OP_TST) begin
                    dec.s = 1'b1;
                end else if (dec.cmd != CMD_NOP) begin
                    dec.s  = s_in;
                    dec.wb = 1'b1;
                end
            end
            default: dec = CTRL_NOP;
        endcase
        if (imm_32_en) begin
            dec.wb  = 1'b1;
            dec.cmd = CMD_ADD;
        end
        if (!cond_pass) begin
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.wb        = 1'b0;
            dec.branch    = 1'b0;
            dec.s         = 1'b0;
        end
    end

    assign hazard = in_valid && ex_valid_q && ex_q.mem_read &&
                    ((src1 == ex_dst_q) ||
                     (two_src && (src2 == ex_dst_q)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            cnt_q      <= 3'd0;
            ex_valid_q <= 1'b0;
            ex_q       <= CTRL_NOP;
            ex_dst_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
            ex_dst_q   <= ex_dst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (branch_flush) begin
            state_d = ST_RUN;
            cnt_d   = 3'd0;
        end else if (!ext_stall) begin
            unique case (state_q)
                ST_RUN: begin
                    if (hazard && (LOAD_STALL_CYCLES > 1)) begin
                        state_d = ST_STALL;
                        cnt_d   = CNT_INIT;
                    end
                end
                ST_STALL: begin
                    if (cnt_q == 3'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        ex_dst_d   = ex_dst_q;
        stall_c    = 1'b0;
        if (branch_flush) begin
            ex_valid_d = 1'b0;
            ex_d       = CTRL_NOP;
            ex_dst_d   = '0;
        end else if (ext_stall) begin
            stall_c = 1'b1;
        end else if (state_q == ST_STALL || hazard) begin
            ex_valid_d = 1'b0;
            ex_d       = CTRL_NOP;
            ex_dst_d   = '0;
            stall_c    = 1'b1;
        end else begin
            ex_valid_d = in_valid;
            ex_d       = in_valid ? dec : CTRL_NOP;
            ex_dst_d   = in_valid ? dst : '0;
        end
    end

    assign id_stall     = rst_n && stall_c;
    assign ex_valid     = ex_valid_q;
    assign ex_cmd       = CMD_W'(ex_q.cmd);
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_wb_en     = ex_q.wb;
    assign ex_branch    = ex_q.branch;
    assign ex_s         = ex_q.s;
    assign ex_dst       = ex_dst_q;

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Scoreboard bench for ctrl_unit_pipe with one- and three-bubble interlocks.
// Expected EX bundles are queued on drive and popped after the edge.
module tb_ctrl_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv1, iv3;
    logic [1:0] mode;
    logic [3:0] opcode, cond, nzcv, src1, src2, dst;
    logic       s_in, imm, two_src, ext_stall, flush;

    logic       v1, rd1, wr1, wb1, br1, s1, st1;
    logic [3:0] cmd1, dst1;
    logic       v3, rd3, wr3, wb3, br3, s3, st3;
    logic [3:0] cmd3, dst3;

    logic [13:0] obs1, obs3, e1, e3;
    logic [13:0] q1[$];
    logic [13:0] q3[$];
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ctrl_unit_pipe #(.CMD_W(4), .RA_W(4), .LOAD_STALL_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .mode(mode),
        .opcode(opcode), .s_in(s_in), .imm_32_en(imm), .cond(cond),
        .status_nzcv(nzcv), .src1(src1), .src2(src2), .two_src(two_src),
        .dst(dst), .ext_stall(ext_stall), .branch_flush(flush),
        .ex_valid(v1), .ex_cmd(cmd1), .ex_mem_read(rd1),
        .ex_mem_write(wr1), .ex_wb_en(wb1), .ex_branch(br1), .ex_s(s1),
        .ex_dst(dst1), .id_stall(st1)
    );

    ctrl_unit_pipe #(.CMD_W(4), .RA_W(4), .LOAD_STALL_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .mode(mode),
        .opcode(opcode), .s_in(s_in), .imm_32_en(imm), .cond(cond),
        .status_nzcv(nzcv), .src1(src1), .src2(src2), .two_src(two_src),
        .dst(dst), .ext_stall(ext_stall), .branch_flush(flush),
        .ex_valid(v3), .ex_cmd(cmd3), .ex_mem_read(rd3),
        .ex_mem_write(wr3), .ex_wb_en(wb3), .ex_branch(br3), .ex_s(s3),
        .ex_dst(dst3), .id_stall(st3)
    );

    assign obs1 = {v1, cmd1, rd1, wr1, wb1, br1, s1, dst1};
    assign obs3 = {v3, cmd3, rd3, wr3, wb3, br3, s3, dst3};

    // {valid, cmd, rd, wr, wb, br, s, dst}
    function automatic logic [13:0] mk(input logic v, input logic [3:0] c,
                                       input logic [4:0] en,
                                       input logic [3:0] d);
        return {v, c, en, d};
    endfunction

    task automatic set_in(input logic [1:0] m, input logic [3:0] op,
                          input logic s, input logic [3:0] a,
                          input logic [3:0] b, input logic two,
                          input logic [3:0] d);
        mode = m; opcode = op; s_in = s; imm = 1'b0;
        cond = 4'b1110; nzcv = 4'b0000;
        src1 = a; src2 = b; two_src = two; dst = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [13:0] LDR3 = 14'b1_0010_10100_0011;
    localparam logic [13:0] ADD4 = 14'b1_0010_00100_0100;

    task automatic test_reset();
        rst_n = 1'b0; iv1 = 1'b1; iv3 = 1'b1;
        ext_stall = 1'b0; flush = 1'b0;
        set_in(2'b00, 4'b0100, 1'b1, 4'd0, 4'd0, 1'b0, 4'd5);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++;
            if (st1 !== 1'b0 || st3 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_stall c%0d got %b%b want 00", c, st1, st3);
            end
            q1.push_back(14'd0); q3.push_back(14'd0);
            tick();
            e1 = q1.pop_front(); e3 = q3.pop_front();
            n_cmp++;
            if (obs1 !== e1) begin
                n_fail++;
                $display("FAIL reset_u1 c%0d got %h want %h", c, obs1, e1);
            end
            n_cmp++;
            if (obs3 !== e3) begin
                n_fail++;
                $display("FAIL reset_u3 c%0d got %h want %h", c, obs3, e3);
            end
        end
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic [1:0] m;
        logic [3:0] op;
        logic       s;
        logic       im;
        logic [3:0] cd;
        logic [3:0] nz;
        logic [9:0] ex;
    } row_t;

    row_t rows[16];

    task automatic test_decode();
        rows[0]  = '{2'b00, 4'b0100, 1'b1, 1'b0, 4'b1110, 4'b0000, 10'b1_0010_00101};
        rows[1]  = '{2'b00, 4'b1010, 1'b0, 1'b0, 4'b1110, 4'b0000, 10'b1_0100_00001};
        rows[2]  = '{2'b00, 4'b0100, 1'b1, 1'b0, 4'b0000, 4'b0000, 10'b1_0010_00000};
        rows[3]  = '{2'b00, 4'b1101, 1'b0, 1'b0, 4'b0001, 4'b0000, 10'b1_0001_00100};
        rows[4]  = '{2'b00, 4'b1111, 1'b1, 1'b0, 4'b1110, 4'b0000, 10'b1_1001_00101};
        rows[5]  = '{2'b00, 4'b0001, 1'b0, 1'b0, 4'b1110, 4'b0000, 10'b1_1000_00100};
        rows[6]  = '{2'b00, 4'b1000, 1'b0, 1'b0, 4'b1110, 4'b0000, 10'b1_0110_00001};
        rows[7]  = '{2'b00, 4'b0110, 1'b0, 1'b0, 4'b1010, 4'b1000, 10'b1_0101_00000};
        rows[8]  = '{2'b01, 4'b0000, 1'b0, 1'b0, 4'b1110, 4'b0000, 10'b1_0010_01000};
        rows[9]  = '{2'b10, 4'b0000, 1'b0, 1'b0, 4'b1110, 4'b0000, 10'b1_0000_00010};
        rows[10] = '{2'b11, 4'b0100, 1'b1, 1'b0, 4'b1110, 4'b0000, 10'b1_0000_00000};
        rows[11] = '{2'b00, 4'b0011, 1'b1, 1'b0, 4'b1110, 4'b0000, 10'b1_0000_00000};
        rows[12] = '{2'b11, 4'b0000, 1'b0, 1'b1, 4'b1110, 4'b0000, 10'b1_0010_00100};
        rows[13] = '{2'b00, 4'b1100, 1'b0, 1'b1, 4'b1110, 4'b0000, 10'b1_0010_00100};
        rows[14] = '{2'b00, 4'b0101, 1'b0, 1'b0, 4'b1000, 4'b0010, 10'b1_0011_00100};
        rows[15] = '{2'b10, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 10'b1_0000_00000};
        for (int i = 0; i < 17; i++) begin
            if (i < 16) begin
                set_in(rows[i].m, rows[i].op, rows[i].s, 4'd0, 4'd0, 1'b0, 4'(i));
                imm = rows[i].im; cond = rows[i].cd; nzcv = rows[i].nz;
                e1 = {rows[i].ex, 4'(i)};
            end else begin
                iv1 = 1'b0; iv3 = 1'b0;
                e1 = 14'd0;
            end
            q1.push_back(e1); q3.push_back(e1);
            tick();
            e1 = q1.pop_front(); e3 = q3.pop_front();
            n_cmp++;
            if (obs1 !== e1) begin
                n_fail++;
                $display("FAIL decode_u1 row%0d got %h want %h", i, obs1, e1);
            end
            n_cmp++;
            if (obs3 !== e3) begin
                n_fail++;
                $display("FAIL decode_u3 row%0d got %h want %h", i, obs3, e3);
            end
        end
    endtask

    task automatic test_load_use();
        logic [13:0] x1[5] = '{LDR3, 14'd0, ADD4, 14'd0, 14'd0};
        logic [13:0] x3[5] = '{LDR3, 14'd0, 14'd0, 14'd0, ADD4};
        logic        s1x[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        s3x[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 5; c++) begin
            if (c == 0) set_in(2'b01, 4'b0000, 1'b1, 4'd0, 4'd0, 1'b0, 4'd3);
            else        set_in(2'b00, 4'b0100, 1'b0, 4'd3, 4'd0, 1'b0, 4'd4);
            iv1 = (c <= 2); iv3 = 1'b1;
            #1;
            n_cmp++;
            if (st1 !== s1x[c] || st3 !== s3x[c]) begin
                n_fail++;
                $display("FAIL loaduse_stall c%0d got %b%b want %b%b",
                         c, st1, st3, s1x[c], s3x[c]);
            end
            q1.push_back(x1[c]); q3.push_back(x3[c]);
            tick();
            e1 = q1.pop_front(); e3 = q3.pop_front();
            n_cmp++;
            if (obs1 !== e1) begin
                n_fail++;
                $display("FAIL loaduse_u1 c%0d got %h want %h", c, obs1, e1);
            end
            n_cmp++;
            if (obs3 !== e3) begin
                n_fail++;
                $display("FAIL loaduse_u3 c%0d got %h want %h", c, obs3, e3);
            end
        end
        iv1 = 1'b0; iv3 = 1'b0;
    endtask

    // src2 only hazards when two_src; flush then rescues u3 from STALL
    task automatic test_two_src_flush();
        logic [13:0] ldr6 = 14'b1_0010_10100_0110;
        logic [13:0] add7 = 14'b1_0010_00100_0111;
        logic [13:0] x[6];
        logic        sx[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        x = '{ldr6, add7, ldr6, 14'd0, 14'd0, 14'd0};
        iv1 = 1'b1; iv3 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            flush = (c == 4);
            if (c == 0 || c == 2)
                set_in(2'b01, 4'b0000, 1'b1, 4'd0, 4'd0, 1'b0, 4'd6);
            else
                set_in(2'b00, 4'b0100, 1'b0, 4'd0, 4'd6, (c != 1), 4'd7);
            if (c == 5) begin iv1 = 1'b0; iv3 = 1'b0; end
            #1;
            n_cmp++;
            if (st1 !== sx[c] || st3 !== sx[c]) begin
                n_fail++;
                $display("FAIL twosrc_stall c%0d got %b%b want %b",
                         c, st1, st3, sx[c]);
            end
            q1.push_back(x[c]); q3.push_back(x[c]);
            tick();
            e1 = q1.pop_front(); e3 = q3.pop_front();
            n_cmp++;
            if (obs1 !== e1) begin
                n_fail++;
                $display("FAIL twosrc_u1 c%0d got %h want %h", c, obs1, e1);
            end
            n_cmp++;
            if (obs3 !== e3) begin
                n_fail++;
                $display("FAIL twosrc_u3 c%0d got %h want %h", c, obs3, e3);
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_ext_stall();
        int idx[6] = '{1, 2, 3, 3, 3, 4};
        int wnt[6] = '{1, 2, 2, 2, 3, 4};
        logic sx[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        iv1 = 1'b1; iv3 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            ext_stall = (c == 2 || c == 3);
            set_in(2'b00, 4'b0100, 1'b0, 4'd0, 4'd0, 1'b0, 4'(idx[c] + 8));
            #1;
            n_cmp++;
            if (st1 !== sx[c] || st3 !== sx[c]) begin
                n_fail++;
                $display("FAIL extstall_stall c%0d got %b%b want %b",
                         c, st1, st3, sx[c]);
            end
            e1 = mk(1'b1, 4'b0010, 5'b00100, 4'(wnt[c] + 8));
            q1.push_back(e1); q3.push_back(e1);
            tick();
            e1 = q1.pop_front(); e3 = q3.pop_front();
            n_cmp++;
            if (obs1 !== e1) begin
                n_fail++;
                $display("FAIL extstall_u1 c%0d got %h want %h", c, obs1, e1);
            end
            n_cmp++;
            if (obs3 !== e3) begin
                n_fail++;
                $display("FAIL extstall_u3 c%0d got %h want %h", c, obs3, e3);
            end
        end
        ext_stall = 1'b0;
    endtask

    task automatic test_flush_vs_stall();
        logic [13:0] x[4];
        logic        sx[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        x = '{mk(1'b1, 4'b0010, 5'b00100, 4'd1), 14'd0, 14'd0,
              mk(1'b1, 4'b0010, 5'b00100, 4'd2)};
        iv1 = 1'b1; iv3 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            flush = (c == 1);
            ext_stall = (c == 1 || c == 2);
            set_in(2'b00, 4'b0100, 1'b0, 4'd0, 4'd0, 1'b0, (c == 0) ? 4'd1 : 4'd2);
            #1;
            n_cmp++;
            if (st1 !== sx[c] || st3 !== sx[c]) begin
                n_fail++;
                $display("FAIL flushwin_stall c%0d got %b%b want %b",
                         c, st1, st3, sx[c]);
            end
            q1.push_back(x[c]); q3.push_back(x[c]);
            tick();
            e1 = q1.pop_front(); e3 = q3.pop_front();
            n_cmp++;
            if (obs1 !== e1) begin
                n_fail++;
                $display("FAIL flushwin_u1 c%0d got %h want %h", c, obs1, e1);
            end
            n_cmp++;
            if (obs3 !== e3) begin
                n_fail++;
                $display("FAIL flushwin_u3 c%0d got %h want %h", c, obs3, e3);
            end
        end
        flush = 1'b0; ext_stall = 1'b0;
    endtask

    task automatic test_reset_in_stall();
        logic [13:0] x[4] = '{LDR3, 14'd0, 14'd0, ADD4};
        logic        sx[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        iv1 = 1'b1; iv3 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rst_n = (c != 2);
            if (c == 0) set_in(2'b01, 4'b0000, 1'b1, 4'd0, 4'd0, 1'b0, 4'd3);
            else        set_in(2'b00, 4'b0100, 1'b0, 4'd3, 4'd0, 1'b0, 4'd4);
            #1;
            n_cmp++;
            if (st1 !== sx[c] || st3 !== sx[c]) begin
                n_fail++;
                $display("FAIL rststall_stall c%0d got %b%b want %b",
                         c, st1, st3, sx[c]);
            end
            q1.push_back(x[c]); q3.push_back(x[c]);
            tick();
            e1 = q1.pop_front(); e3 = q3.pop_front();
            n_cmp++;
            if (obs1 !== e1) begin
                n_fail++;
                $display("FAIL rststall_u1 c%0d got %h want %h", c, obs1, e1);
            end
            n_cmp++;
            if (obs3 !== e3) begin
                n_fail++;
                $display("FAIL rststall_u3 c%0d got %h want %h", c, obs3, e3);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_load_use();
        test_two_src_flush();
        test_ext_stall();
        test_flush_vs_stall();
        test_reset_in_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_unit_pipe.md
Name: ctrl_unit_pipe

Overview:
Parametrised successor to the ID-stage control decoder. Decodes mode/opcode/S/imm into the control bundle and evaluates the ARM condition field against the NZCV status. Detects load-use hazards and registers the bundle into the ID/EX pipeline register, with stall and flush support. Sits between the ID stage and the EX stage, and drives the IF/ID hold signal.

Parameters:
CMD_W, 4, ALU command width
RA_W, 4, register-address width
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal range 1..7)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  ID holds a real instruction
mode  in  2  00 normal, 01 memory, 10 branch, 11 reserved
opcode  in  4  data-processing opcode
s_in  in  1  S bit (load/store select in memory mode)
imm_32_en  in  1  32-bit immediate form, forces wb and ADD
cond  in  4  ARM condition field
status_nzcv  in  4  current flags {N,Z,C,V}
src1  in  RA_W  first source register
src2  in  RA_W  second source register
two_src  in  1  src2 is actually read
dst  in  RA_W  destination register
ext_stall  in  1  memory/back-end stall; freeze pipeline
branch_flush  in  1  taken branch resolved in EX; squash ID
ex_valid  out  1  registered: EX instruction is real
ex_cmd  out  CMD_W  registered ALU command
ex_mem_read  out  1  registered load enable
ex_mem_write  out  1  registered store enable
ex_wb_en  out  1  registered write-back enable
ex_branch  out  1  registered branch enable
ex_s  out  1  registered flag-update enable
ex_dst  out  RA_W  registered destination
id_stall  out  1  combinational: hold IF/ID and PC

Behaviour:
- Reset (rst_n=0 at clk edge): all ex_* outputs = 0, FSM = RUN, stall counter = 0. id_stall = 0 while in reset.
- Decode, combinational, all fields default 0:
  - Memory mode: cmd=ADD(0010). s_in=1 gives mem_read=1 and wb=1. s_in=0 gives mem_write=1.
  - Branch mode: branch=1.
  - Normal mode: s=s_in, wb=1, with cmd by opcode: MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111, EOR 0001→1000.
  - Normal mode, compare ops: CMP 1010→0100 and TST 1000→0110, each with s=1 and wb=0.
  - Normal mode, unlisted opcode: all 0.
  - Mode 11: all 0.
  - imm_32_en=1 overrides to wb=1 and cmd=ADD.
- Condition check uses standard ARM encodings: EQ..LE (0000..1101), AL=1110, 1111=never. A failed condition zeroes mem_read, mem_write, wb, branch and s; ex_valid is still 1.
- Load-use hazard = in_valid & ex_valid & ex_mem_read & (src1==ex_dst | (two_src & src2==ex_dst)).
- Priority per cycle, highest first: reset > branch_flush > ext_stall > hazard > normal issue.
- branch_flush:
  - Next cycle is a bubble: ex_valid=0 and all enables 0.
  - FSM goes to RUN and the counter is cleared.
  - id_stall=0, so the fetch redirect proceeds.
- ext_stall:
  - All ex_* registers, FSM state and counter hold.
  - id_stall=1.
- FSM states are RUN and STALL.
  - RUN with hazard: register a bubble and set id_stall=1. If LOAD_STALL_CYCLES==1, stay in RUN. Otherwise go to STALL with cnt=LOAD_STALL_CYCLES-2.
  - STALL: register a bubble and set id_stall=1. If cnt==0, go to RUN; else cnt-1.
  - RUN, no hazard: register the decoded bundle, with ex_valid=in_valid. When in_valid=0, all enables are 0.
- A bubble registered after a hazard clears ex_mem_read, so the held instruction cannot re-trigger on return to RUN.
- Hazard detection is evaluated in RUN only.
- The counter width is 3 bits.

Decomposition:
- Shared package ctrl_pkg holds:
  - mode constants
  - opcode constants
  - ALU command constants
  - condition-code constants
  - FSM state enum
  - the control-bundle typedef
- One combinational sub-module, ctrl_cond_eval (cond, nzcv → pass). It is reused by the branch unit.

Test Plan:
- Normal mode, opcode 0100, s_in=1, cond=1110, in_valid=1 → next cycle ex_cmd=0010, ex_wb_en=1, ex_s=1, ex_valid=1.
- CMP (opcode 1010, s_in=0) → ex_s=1, ex_wb_en=0, ex_cmd=0100. Then EQ (cond 0000) with nzcv=0000 → ex_valid=1 and all enables 0.
- LDR to r3 issued, then ADD reading src1=r3 → one bubble cycle (ex_valid=0, id_stall=1), then ADD issues. Same sequence with LOAD_STALL_CYCLES=3 → exactly 3 bubbles.
- ext_stall=1 for 2 cycles in the middle of a stream → ex_* frozen and id_stall=1 on both cycles, then resume with no instruction lost or duplicated.
- branch_flush during STALL (LOAD_STALL_CYCLES=3) → next cycle bubble, FSM in RUN, id_stall=0. Flush asserted together with ext_stall → flush wins.
- rst_n=0 asserted during STALL → next edge: all outputs 0, RUN, counter 0.
